// File: rtl/tcp_tx_arb_pkg.sv
// Shared types for the put-command arbiter in front of dma_put_data_to_net.
// Command layout, FSM states and a length helper.
package tcp_tx_arb_pkg;

  localparam int PUT_CMD_W = 112;

  typedef struct packed {
    logic [15:0] session;
    logic [31:0] length;
    logic [31:0] block;
    logic [31:0] offset;
  } put_cmd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_t;

  function automatic logic has_payload(put_cmd_t c);
    return c.length != '0;
  endfunction

endpackage

// File: rtl/tcp_tx_cmd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Searches from i_last_grant+1 with wrap; lowest distance wins.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last_grant,
  output logic          o_found,
  output logic [IW-1:0] o_index
);

  logic [IW-1:0] w_j;

  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_j     = '0;
    for (int k = N; k >= 1; k--) begin
      w_j = IW'((int'(i_last_grant) + k) % N);
      if (i_req[w_j]) begin
        o_found = 1'b1;
        o_index = w_j;
      end
    end
  end

endmodule

// File: rtl/tcp_tx_cmd_arbiter.sv
// Round-robin arbiter and credit scheduler for put commands.
// Optional macro TX_ARB_STATS_EN adds grant counters and a stall count.
module tcp_tx_cmd_arbiter
  import tcp_tx_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             s_cmd_valid,
  output logic [NUM_REQ-1:0]             s_cmd_ready,
  input  logic [NUM_REQ*PUT_CMD_W-1:0]   s_cmd_data,
  output logic                           m_axis_cmd_valid,
  input  logic                           m_axis_cmd_ready,
  output logic [PUT_CMD_W-1:0]           m_axis_cmd_data,
  input  logic                           cmd_done,
  input  logic                           enable,
`ifdef TX_ARB_STATS_EN
  output logic [NUM_REQ*32-1:0]          grant_cnt,
`endif
  output logic [31:0]                    status
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t    r_state;
  put_cmd_t      r_data;
  logic          r_valid;
  logic [IW-1:0] r_last;
  logic [3:0]    r_out;
  logic          r_err;
  logic [31:0]   r_status;

  logic          w_found;
  logic [IW-1:0] w_idx;
  put_cmd_t      w_win;
  logic          w_credit_ok;
  logic          w_grant;
  logic          w_inc;
  logic          w_dec;
  logic          w_uf;
  logic [15:0]   w_stat_hi;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .i_req        (s_cmd_valid),
    .i_last_grant (r_last),
    .o_found      (w_found),
    .o_index      (w_idx)
  );

  assign w_win = put_cmd_t'(s_cmd_data[int'(w_idx)*PUT_CMD_W +: PUT_CMD_W]);
  assign w_credit_ok = r_out < 4'(MAX_OUTSTANDING);
  assign w_grant = rstn && (r_state == ST_IDLE) && w_found
                && enable && w_credit_ok;
  assign w_inc = w_grant && has_payload(w_win);
  assign w_dec = cmd_done && (r_out != 4'd0);
  assign w_uf  = cmd_done && (r_out == 4'd0);

  assign m_axis_cmd_valid = r_valid;
  assign m_axis_cmd_data  = r_data;
  assign status           = r_status;

  // Same-cycle accept strobe to the winning requester.
  always_comb begin
    s_cmd_ready = '0;
    if (w_grant) s_cmd_ready[w_idx] = 1'b1;
  end

  // Grant / send FSM; zero-length commands are consumed in IDLE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= IW'(NUM_REQ - 1);
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_last <= w_idx;
            r_data <= w_win;
            if (has_payload(w_win)) begin
              r_valid <= 1'b1;
              r_state <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (m_axis_cmd_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Credit counter and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out <= 4'd0;
      r_err <= 1'b0;
    end else begin
      if (w_inc && !w_dec)
        r_out <= r_out + 4'd1;
      else if (!w_inc && w_dec)
        r_out <= r_out - 4'd1;
      if (w_uf) r_err <= 1'b1;
    end
  end

`ifdef TX_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] r_gcnt;
  logic [15:0]              r_stall;
  logic                     w_stall;

  assign w_stall = (r_state == ST_IDLE) && w_found
                && enable && !w_credit_ok;
  assign grant_cnt = r_gcnt;
  assign w_stat_hi = r_stall;

  // Per-requester grant counters and credit-stall cycle count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_gcnt  <= '0;
      r_stall <= '0;
    end else begin
      if (w_grant) r_gcnt[w_idx] <= r_gcnt[w_idx] + 32'd1;
      if (w_stall && r_stall != 16'hFFFF)
        r_stall <= r_stall + 16'd1;
    end
  end
`else
  assign w_stat_hi = 16'd0;
`endif

  // Status snapshot, one cycle behind internal state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_status <= {16'd0, 6'd0, 1'b0, 1'b0,
                   4'(NUM_REQ - 1), 4'd0};
    end else begin
      r_status <= {w_stat_hi, 6'd0, (r_state != ST_IDLE),
                   r_err, 4'(r_last), r_out};
    end
  end

endmodule
